// File: rtl/mbist_pkg.sv
// Shared types for the March C- MBIST controller: FSM states and the
// per-element encoding of address order, op list and data polarity.
package mbist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam int MARCH_CM_NUM_ELEM = 6;
  localparam int ELEM_IDX_W        = 3;

  typedef logic [ELEM_IDX_W-1:0] elem_idx_t;

  // Ops per address for M0..M5; the sum (10) sets the run length.
  localparam int OPS_PER_ADDR [MARCH_CM_NUM_ELEM] = '{1, 2, 2, 2, 2, 1};

  // Slot 0 is the first op at an address, slot 1 the second (if any).
  typedef struct packed {
    logic       down;
    logic [1:0] num_ops;
    logic [1:0] is_read;
    logic [1:0] data_one;
  } march_elem_t;

  function automatic march_elem_t march_elem(input elem_idx_t idx);
    march_elem_t e;
    e = '0;
    case (idx)
      3'd0: e = '{down: 1'b0, num_ops: 2'(OPS_PER_ADDR[0]), is_read: 2'b00, data_one: 2'b00};
      3'd1: e = '{down: 1'b0, num_ops: 2'(OPS_PER_ADDR[1]), is_read: 2'b01, data_one: 2'b10};
      3'd2: e = '{down: 1'b0, num_ops: 2'(OPS_PER_ADDR[2]), is_read: 2'b01, data_one: 2'b01};
      3'd3: e = '{down: 1'b1, num_ops: 2'(OPS_PER_ADDR[3]), is_read: 2'b01, data_one: 2'b10};
      3'd4: e = '{down: 1'b1, num_ops: 2'(OPS_PER_ADDR[4]), is_read: 2'b01, data_one: 2'b01};
      3'd5: e = '{down: 1'b0, num_ops: 2'(OPS_PER_ADDR[5]), is_read: 2'b01, data_one: 2'b00};
      default: e = '0;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/mbist_march_ctrl_if.sv
// Single-port test memory bus: controller drives op/address/data,
// memory returns read data two cycles after the address.
interface mbist_march_ctrl_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic                  write_read;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output write_read, address, wdata, input rdata);
  modport slave  (input write_read, address, wdata, output rdata);
endinterface

// File: rtl/mbist_addr_gen.sv
// Up/down address counter for march elements: load picks the start end
// of the range from the direction, step moves one address, last flags the end.
module mbist_addr_gen #(
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  dir_down,
  input  logic                  step,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);
  localparam logic [ADDR_WIDTH-1:0] TOP = ADDR_WIDTH'(DEPTH - 1);

  logic down;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
      down <= 1'b0;
    end else if (load) begin
      down <= dir_down;
      addr <= dir_down ? TOP : '0;
    end else if (step) begin
      addr <= down ? addr - ADDR_WIDTH'(1) : addr + ADDR_WIDTH'(1);
    end
  end

  assign last = down ? (addr == '0) : (addr == TOP);

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- MBIST initiator for the single-port test memory.
// Optional build macro MBIST_STOP_ON_FAIL_EN ends the run at the first mismatch.
module mbist_march_ctrl
  import mbist_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  mbist_march_ctrl_if.master    mem,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data
);
  localparam elem_idx_t LAST_ELEM = elem_idx_t'(MARCH_CM_NUM_ELEM - 1);

  state_t                state, state_nxt;
  logic                  phase;
  elem_idx_t             elem;
  logic                  op_idx;
  logic                  ptr_valid;
  march_elem_t           cur, nxt;
  logic                  ptr_read, ptr_one, last_op;
  logic [ADDR_WIDTH-1:0] gen_addr;
  logic                  gen_last, gen_load, gen_dir, gen_step;
  logic                  accept, issue, load_wdata, mismatch, stop;

  // Read-compare delay line: issue edge -> three edges -> compare edge.
  logic [2:0]            pv;
  logic [DATA_WIDTH-1:0] pe [3];
  logic [ADDR_WIDTH-1:0] pa [3];

  // ---------------- march pointer (next op to issue) ----------------
  assign cur      = march_elem(elem);
  assign nxt      = march_elem(elem + elem_idx_t'(1));
  assign ptr_read = cur.is_read[op_idx];
  assign ptr_one  = cur.data_one[op_idx];
  assign last_op  = (cur.num_ops == 2'd1) | op_idx;

  assign gen_step = issue & last_op & ~gen_last;
  assign gen_load = accept | (issue & last_op & gen_last & (elem != LAST_ELEM));
  assign gen_dir  = accept ? 1'b0 : nxt.down;

  mbist_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (gen_load),
    .dir_down (gen_dir),
    .step     (gen_step),
    .addr     (gen_addr),
    .last     (gen_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      elem      <= '0;
      op_idx    <= 1'b0;
      ptr_valid <= 1'b0;
    end else if (accept) begin
      elem      <= '0;
      op_idx    <= 1'b0;
      ptr_valid <= 1'b1;
    end else if (issue) begin
      if (!last_op) begin
        op_idx <= 1'b1;
      end else begin
        op_idx <= 1'b0;
        if (gen_last) begin
          if (elem == LAST_ELEM) ptr_valid <= 1'b0;
          else                   elem      <= elem + elem_idx_t'(1);
        end
      end
    end
  end

  // ---------------- compare ----------------
  assign mismatch = pv[2] & (mem.rdata != pe[2]);

`ifdef MBIST_STOP_ON_FAIL_EN
  assign stop = mismatch;
`else
  assign stop = 1'b0;
`endif

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  // NOTE: every combinational output gets a default first, so no path
  // through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = PREP;
      PREP:  state_nxt = RUN;
      RUN: begin
        if (stop)                     state_nxt = DONE;
        else if (phase && !ptr_valid) state_nxt = DRAIN;
      end
      DRAIN: if (stop || (!pv[0] && !pv[1])) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs / strobes ----------------
  // An op occupies two cycles: wdata for the next op loads at its midpoint
  // edge, address/write_read at its end edge.
  always_comb begin
    busy       = 1'b1;
    accept     = 1'b0;
    issue      = 1'b0;
    load_wdata = 1'b0;
    case (state)
      IDLE: begin
        busy   = 1'b0;
        accept = start;
      end
      PREP: issue = 1'b1;
      RUN: begin
        issue      = phase & ptr_valid & ~stop;
        load_wdata = ~phase & ~stop;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase <= 1'b0;
    else        phase <= (state == RUN) ? ~phase : 1'b0;
  end

  // ---------------- memory bus ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem.write_read <= 1'b0;
      mem.address    <= '0;
      mem.wdata      <= '0;
    end else if (accept) begin
      mem.write_read <= 1'b0;
      mem.address    <= '0;
      mem.wdata      <= '0;
    end else begin
      if (issue) begin
        mem.address    <= gen_addr;
        mem.write_read <= ~ptr_read;
      end else if (state_nxt != RUN) begin
        mem.write_read <= 1'b0;
      end
      if (load_wdata && state_nxt == RUN)
        mem.wdata <= (ptr_valid && !ptr_read && ptr_one) ? '1 : '0;
      else if (state_nxt != RUN)
        mem.wdata <= '0;
    end
  end

  // ---------------- compare pipeline ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            pv <= '0;
    else if (accept || state_nxt == DONE)  pv <= '0;
    else                                   pv <= {pv[1:0], issue & ptr_read};
  end

  // NOTE: the expected-data/address stages are qualified by pv, so they
  // carry no reset and stay plain data registers.
  always_ff @(posedge clk) begin
    pe[0] <= ptr_one ? '1 : '0;
    pa[0] <= gen_addr;
    pe[1] <= pe[0];
    pa[1] <= pa[0];
    pe[2] <= pe[1];
    pa[2] <= pa[1];
  end

  // ---------------- status ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done      <= 1'b0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
    end else if (accept) begin
      done      <= 1'b0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
    end else begin
      if (state == DONE) done <= 1'b1;
      if (mismatch && !fail) begin
        fail      <= 1'b1;
        fail_addr <= pa[2];
        fail_data <= mem.rdata;
      end
    end
  end

endmodule

// File: doc/mbist_march_ctrl.md
Name: mbist_march_ctrl

Overview:
MBIST initiator that runs March C- on the single-port test memory (fault_mem family) through its write_read/address/wdata/rdata interface. Sequences addresses, data backgrounds and up/down order, and schedules ops to match the memory's one-cycle write-data register and two-cycle read path. Compares read data and reports pass/fail plus the first failing address and data. Sits between the BIST top-level start/status and the memory under test.

Parameters:
DATA_WIDTH, 8, memory word width
ADDR_WIDTH, 4, memory address width
DEPTH, 16, number of addresses tested (0..DEPTH-1), DEPTH <= 2**ADDR_WIDTH

Ports:
clk  in  1  clock; all logic on posedge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; accepted only in IDLE
write_read  out  1  1=write, 0=read; to memory
address  out  ADDR_WIDTH  to memory
wdata  out  DATA_WIDTH  to memory; leads address by one cycle
rdata  in  DATA_WIDTH  from memory
busy  out  1  high from the cycle after start is accepted until done
done  out  1  sticky; cleared by next accepted start
fail  out  1  sticky mismatch flag; cleared by next accepted start
fail_addr  out  ADDR_WIDTH  address of first mismatch
fail_data  out  DATA_WIDTH  rdata of first mismatch

Behaviour:
- Reset: all outputs 0; FSM in IDLE. Reset mid-test aborts immediately. Memory contents are not restored.
- March C- elements:
  - M0 up(w0)
  - M1 up(r0,w1)
  - M2 up(r1,w0)
  - M3 down(r0,w1)
  - M4 down(r1,w0)
  - M5 up(r0)
- 0 = all-zeros word, 1 = all-ones word. Total ops = 10*DEPTH.
- FSM: IDLE -> PREP (1 cycle) -> RUN -> DRAIN -> DONE -> IDLE. DONE lasts one cycle, then IDLE; done stays high.
- Timing, with E0 = the edge sampling start=1 and op index i = 0..10*DEPTH-1:
  - address/write_read for op i are valid after edge E0+1+2i and held 2 cycles.
  - wdata for op i is valid after edge E0+2i and held 2 cycles.
  - wdata is 0 during PREP. For a read op, wdata is don't-care; drive 0.
- Memory alignment: the memory commits a write at edge E0+2+2i. A read's data is on rdata at edge E0+4+2i, and the compare is sampled there.
- Compare pipeline: the expected value and address travel through a 3-stage valid/expected/address delay line. No compare occurs during writes.
- Address counter: up elements run 0..DEPTH-1, down elements run DEPTH-1..0. Element changes on the last address; no wrap between elements.
- Mismatch handling: on the first mismatch, set fail and latch fail_addr/fail_data. Later mismatches set nothing new.
- DRAIN waits until the last read compare edge (E0+20*DEPTH+2). done and IDLE follow at E0+20*DEPTH+3.
- start while not IDLE is ignored. start in the same cycle as the DONE->IDLE transition is ignored.

Optional Feature:
- Macro: MBIST_STOP_ON_FAIL_EN.
- Defined: the first mismatch goes directly to DONE. done is high after the next edge, ops stop, write_read=0, and further compares are discarded.
- Undefined: the full march always completes. fail_addr/fail_data still hold the first failure.

Decomposition:
- Shared package mbist_pkg:
  - FSM state enum (IDLE, PREP, RUN, DRAIN, DONE)
  - march element encoding (direction, op list, data polarity)
  - MARCH_CM_NUM_ELEM = 6
  - OPS_PER_ADDR table
- Sub-module mbist_addr_gen: up/down address counter with load, step and last-address flag.

Test Plan:
- Fault-free model, DEPTH=16 -> done high exactly 323 cycles after the start edge; fail=0; busy high for that span.
- TF rising on bit 2 at address 3 (a write of 0xFF stores 0xFB) -> fail=1, fail_addr=3, fail_data=0xFB, first flagged in M2.
- Stuck-at-1 on bit 0 at address 15, macro defined -> M1 read of address 15 returns 0x01; done high one cycle after that compare; fail_addr=15.
- Same fault, macro undefined -> run completes at cycle 323; fail_addr=15, fail_data=0x01.
- rst_n low at cycle 100 of a run -> all outputs 0 asynchronously; a new start then gives a full 323-cycle run.
- start pulsed during RUN and during DONE -> ignored; only one run; done/fail not cleared.
